stack_ctrl: RTL and testbench

Front-end controller for the `Stack` LIFO.
- Accepts push/pop requests from a producer over a valid/ready handshake and drives the stack's `push`/`pop`/`d`/`reset` pins.
- Returns popped words to a consumer over a second valid/ready handshake.
- Tracks occupancy so the stack never overflows or underflows, and reports full, empty, occupancy and a high-water mark.
- Sits directly upstream of `Stack` (drives it) and downstream of it (consumes its `q`).

---
 rtl/stack_ctrl.sv | 89 ++++++++
 tb/tb_stack_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_ctrl.sv
// stack_ctrl: valid/ready front end for an external LIFO. Tracks occupancy and
// a high-water mark, and hands popped words to the consumer through a one-entry slot.
module stack_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 7,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    hwm,
  output logic             stk_reset,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_d,
  input  logic [WIDTH-1:0] stk_q
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic          clr;
  logic          push_ok, pop_ok;
  logic          push_acc, pop_acc;
  logic [CW-1:0] count_q, count_next, hwm_q;
  logic          out_valid_q, out_valid_next;

  // Flush and reset are equivalent here: both block acceptance and clear state.
  assign clr     = reset | flush;
  assign push_ok = ~clr & (count_q != FULL_CNT);
  // A pop may only issue if its result has somewhere to land next cycle.
  assign pop_ok  = ~clr & (count_q != '0) & (~out_valid_q | out_ready);

  assign in_ready = in_op ? pop_ok : push_ok;
  assign push_acc = in_valid & push_ok & ~in_op;
  assign pop_acc  = in_valid & pop_ok & in_op;

  assign stk_reset = clr;
  assign stk_push  = push_acc;
  assign stk_pop   = pop_acc;
  assign stk_d     = in_data;
  // The stack holds q until its next pop, so no local copy is needed.
  assign out_data  = stk_q;

  assign out_valid = out_valid_q;
  assign count     = count_q;
  assign hwm       = hwm_q;
  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);

  always_comb begin
    count_next = count_q;
    if (push_acc)
      count_next = count_q + CW'(1);
    else if (pop_acc)
      count_next = count_q - CW'(1);
  end

  always_comb begin
    out_valid_next = out_valid_q;
    if (pop_acc)
      out_valid_next = 1'b1;
    else if (out_ready)
      out_valid_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      count_q     <= '0;
      hwm_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_next;
      out_valid_q <= out_valid_next;
      if (count_next > hwm_q)
        hwm_q <= count_next;
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: behavioural LIFO on the stack pins, a queue reference
// model with an expected-output scoreboard, a vector table and corner sequences.
module tb_stack_ctrl;
  localparam int W  = 32;
  localparam int D  = 7;
  localparam int CW = $clog2(D + 1);

  logic          clk;
  logic          reset, flush, in_valid, in_op, out_ready;
  logic [W-1:0]  in_data;
  logic          in_ready, out_valid, full, empty;
  logic [W-1:0]  out_data, stk_d, stk_q;
  logic [CW-1:0] count, hwm;
  logic          stk_reset, stk_push, stk_pop;

  stack_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_op(in_op), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty), .hwm(hwm),
    .stk_reset(stk_reset), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_d(stk_d), .stk_q(stk_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External stack: registered q, updated only on pop.
  logic [W-1:0] mem [0:D-1];
  int sp = 0;
  always @(posedge clk) begin
    if (stk_reset) sp <= 0;
    else if (stk_push && sp < D) begin mem[sp] <= stk_d; sp <= sp + 1; end
    else if (stk_pop && sp > 0) begin stk_q <= mem[sp-1]; sp <= sp - 1; end
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (values visible during the current cycle).
  int           ref_cnt = 0, ref_hwm = 0;
  logic         ref_ov = 1'b0;
  logic [W-1:0] ref_mem[$];
  logic [W-1:0] exp_q[$];
  logic         cur_op, cur_ordy, cur_clr, cur_acc;
  logic [W-1:0] cur_d;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Apply inputs for one cycle and compare everything against the model.
  task automatic drive(input logic v, input logic op, input logic [W-1:0] d,
                       input logic ordy, input logic fl, input logic rs);
    logic m_rdy;
    in_valid = v; in_op = op; in_data = d; out_ready = ordy; flush = fl; reset = rs;
    #1;
    cur_clr  = fl | rs;
    m_rdy    = !cur_clr && (op ? (ref_cnt != 0 && (!ref_ov || ordy)) : (ref_cnt != D));
    cur_acc  = v && m_rdy;
    cur_op   = op; cur_d = d; cur_ordy = ordy;
    chk("in_ready", in_ready, m_rdy);
    chk("stk_push", stk_push, cur_acc && !op);
    chk("stk_pop", stk_pop, cur_acc && op);
    chk("stk_reset", stk_reset, cur_clr);
    chk("count", count, ref_cnt);
    chk("hwm", hwm, ref_hwm);
    chk("out_valid", out_valid, ref_ov);
    chk("full", full, ref_cnt == D);
    chk("empty", empty, ref_cnt == 0);
    if (ref_ov) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL scoreboard: got out_valid with no expected word");
      end else
        chk("out_data", out_data, exp_q[0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (cur_clr) begin
      ref_cnt = 0; ref_hwm = 0; ref_ov = 1'b0;
      ref_mem.delete(); exp_q.delete();
    end else begin
      if (ref_ov && cur_ordy) begin
        void'(exp_q.pop_front());
        ref_ov = 1'b0;
      end
      if (cur_acc && !cur_op) begin ref_mem.push_back(cur_d); ref_cnt++; end
      if (cur_acc && cur_op) begin
        exp_q.push_back(ref_mem.pop_back());
        ref_cnt--;
        ref_ov = 1'b1;
      end
      if (ref_cnt > ref_hwm) ref_hwm = ref_cnt;
    end
    @(negedge clk);
  endtask

  task automatic cyc(input logic v, input logic op, input logic [W-1:0] d,
                     input logic ordy, input logic fl, input logic rs);
    drive(v, op, d, ordy, fl, rs);
    tick();
  endtask

  typedef struct {
    logic v, op; logic [W-1:0] d; logic ordy, rs;
    logic e_rdy; int e_cnt, e_hwm; logic e_ov; logic [W-1:0] e_q;
  } vec_t;
  vec_t tab[$];

  function automatic vec_t mk(logic v, logic op, logic [W-1:0] d, logic ordy, logic rs,
                              logic e_rdy, int e_cnt, int e_hwm, logic e_ov, logic [W-1:0] e_q);
    vec_t r;
    r.v = v; r.op = op; r.d = d; r.ordy = ordy; r.rs = rs;
    r.e_rdy = e_rdy; r.e_cnt = e_cnt; r.e_hwm = e_hwm; r.e_ov = e_ov; r.e_q = e_q;
    return r;
  endfunction

  localparam logic PU = 1'b0, PO = 1'b1;

  initial begin
    // Fill 0x11..0x77, blocked 8th push, drain LIFO order.
    for (int i = 0; i < 7; i++)
      tab.push_back(mk(1, PU, W'((i + 1) * 32'h11), 1, 0, 1, i, i, 0, 0));
    tab.push_back(mk(1, PU, 32'h88, 1, 0, 0, 7, 7, 0, 0));
    tab.push_back(mk(1, PO, 0, 1, 0, 1, 7, 7, 0, 0));
    for (int i = 0; i < 6; i++)
      tab.push_back(mk(1, PO, 0, 1, 0, 1, 6 - i, 7, 1, W'((7 - i) * 32'h11)));
    tab.push_back(mk(0, PU, 0, 1, 0, 1, 0, 7, 1, 32'h11));
    tab.push_back(mk(0, PU, 0, 1, 0, 1, 0, 7, 0, 0));
    // Reset, then pop from empty for 3 cycles.
    tab.push_back(mk(0, PU, 0, 1, 1, 0, 0, 7, 0, 0));
    for (int i = 0; i < 3; i++)
      tab.push_back(mk(1, PO, 0, 1, 0, 0, 0, 0, 0, 0));

    in_valid = 0; in_op = 0; in_data = '0; out_ready = 0; flush = 0; reset = 1;
    stk_q = '0;
    @(posedge clk); @(negedge clk);
    cyc(0, PU, 0, 0, 0, 1);

    for (int i = 0; i < tab.size(); i++) begin
      drive(tab[i].v, tab[i].op, tab[i].d, tab[i].ordy, 1'b0, tab[i].rs);
      chk($sformatf("tab%0d in_ready", i), in_ready, tab[i].e_rdy);
      chk($sformatf("tab%0d count", i), count, tab[i].e_cnt);
      chk($sformatf("tab%0d hwm", i), hwm, tab[i].e_hwm);
      chk($sformatf("tab%0d out_valid", i), out_valid, tab[i].e_ov);
      if (tab[i].e_ov) chk($sformatf("tab%0d out_data", i), out_data, tab[i].e_q);
      tick();
    end

    // Consumer back-pressure.
    cyc(1, PU, 32'hA, 1, 0, 0);
    cyc(1, PU, 32'hB, 1, 0, 0);
    cyc(1, PO, 0, 0, 0, 0);
    drive(1, PO, 0, 0, 0, 0);
    chk("bp pop blocked", in_ready, 0);
    tick();
    drive(1, PU, 32'hC, 0, 0, 0);
    chk("bp push ready", in_ready, 1);
    tick();
    chk("bp count", count, 2);
    cyc(0, PU, 0, 0, 0, 0);
    cyc(0, PU, 0, 0, 0, 0);
    chk("bp held valid", out_valid, 1);
    chk("bp held data", out_data, 32'hB);
    cyc(0, PU, 0, 1, 0, 0);
    cyc(1, PO, 0, 1, 0, 0);
    chk("bp pop C", out_data, 32'hC);
    cyc(0, PU, 0, 1, 0, 0);

    // Interleave.
    cyc(0, PU, 0, 1, 0, 1);
    cyc(1, PU, 32'h1, 1, 0, 0);
    cyc(1, PU, 32'h2, 1, 0, 0);
    cyc(1, PO, 0, 1, 0, 0);
    chk("il ret 2", out_data, 32'h2);
    cyc(1, PU, 32'h3, 1, 0, 0);
    cyc(1, PO, 0, 1, 0, 0);
    chk("il ret 3", out_data, 32'h3);
    cyc(1, PO, 0, 1, 0, 0);
    chk("il ret 1", out_data, 32'h1);
    cyc(0, PU, 0, 1, 0, 0);
    chk("il hwm", hwm, 2);
    chk("il count", count, 0);

    // Flush with 5 entries, a pending word and a push in the flush cycle.
    for (int i = 0; i < 6; i++) cyc(1, PU, W'(32'h40 + i), 1, 0, 0);
    cyc(1, PO, 0, 0, 0, 0);
    chk("fl pre count", count, 5);
    drive(1, PU, 32'h99, 0, 1, 0);
    chk("fl push blocked", in_ready, 0);
    tick();
    chk("fl count", count, 0);
    chk("fl hwm", hwm, 0);
    chk("fl out_valid", out_valid, 0);
    cyc(1, PU, 32'h5, 1, 0, 0);
    cyc(1, PO, 0, 1, 0, 0);
    chk("fl ret 5", out_data, 32'h5);
    cyc(0, PU, 0, 1, 0, 0);

    // Reset with 3 entries and out_valid high.
    for (int i = 0; i < 4; i++) cyc(1, PU, W'(32'h70 + i), 1, 0, 0);
    cyc(1, PO, 0, 0, 0, 0);
    chk("rs pre count", count, 3);
    cyc(1, PO, 0, 0, 0, 1);
    chk("rs count", count, 0);
    chk("rs hwm", hwm, 0);
    chk("rs out_valid", out_valid, 0);
    chk("rs empty", empty, 1);
    chk("rs full", full, 0);
    cyc(1, PU, 32'hE, 1, 0, 0);
    cyc(1, PO, 0, 1, 0, 0);
    chk("rs ret E", out_data, 32'hE);
    drive(1, PO, 0, 1, 0, 0);
    chk("rs empty pop blocked", in_ready, 0);
    tick();
    cyc(0, PU, 0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
